uart_rx_byte: RTL and testbench
===============================

Name: uart_rx_byte

Overview:
UART 8N1 receiver. It converts the asynchronous serial line from the host into bytes, each with a single-cycle write strobe. It sits directly upstream of the 128-bit SIPO block in the AES-over-UART path. rx_data and rx_valid connect straight to the SIPO's serial_in and Wr, so sixteen received bytes form one AES block.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range 4 to 65535
HALF_BIT, CLKS_PER_BIT/2, derived (localparam), cycles from start-bit detection to mid-start sample

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
rx  input  1  raw serial line, idle high, asynchronous to clk
rx_data  output  8  last correctly framed byte, LSB received first
rx_valid  output  1  one-cycle pulse, rx_data newly valid (drives SIPO Wr)
frame_err  output  1  one-cycle pulse, stop bit sampled low
busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Clock and reset: one clock domain; reset is asynchronous and active-high.
- Reset values: rx_data=8'h00, rx_valid=0, frame_err=0, busy=0, FSM=IDLE, counters=0, shift register=0. Both synchronizer flops reset to 1 (line idle).
- Synchronizer: rx passes through 2 flops to give rx_s. The FSM uses only rx_s.
- Counters: a 16-bit cycle counter cnt clears on every state or bit transition and increments by 1 each cycle otherwise. A 3-bit bit index counts 0..7.
- Edge numbering: E0 is the first clock edge at which rx is sampled low. rx_s is low after E1.
- IDLE: busy=0. If rx_s==0, go to START with cnt=0 at E2.
- START: when cnt==HALF_BIT-1, check rx_s.
  - rx_s==0: go to DATA with cnt=0 and bit index=0.
  - rx_s==1: glitch; return to IDLE. No output of any kind.
- DATA: when cnt==CLKS_PER_BIT-1, shift rx_s into the shift register MSB-first-in-position, so bit 0 ends up as LSB (right-shift insert at bit 7).
  - Bit index increments on each sample. After the 8th sample (index 7), go to STOP.
- STOP: when cnt==CLKS_PER_BIT-1, check rx_s.
  - rx_s==1: load rx_data from the shift register, pulse rx_valid for exactly 1 cycle, go to IDLE.
  - rx_s==0: pulse frame_err for 1 cycle, leave rx_data unchanged, go to BREAK_WAIT.
- BREAK_WAIT: stay until rx_s==1, then go to IDLE. This stops a held-low line (break) from being decoded as repeated 0x00 frames.
- Latency: the stop sample falls at edge E(2+HALF_BIT+9*CLKS_PER_BIT). rx_valid is high for the single cycle following that edge.
  - With CLKS_PER_BIT=16 (HALF_BIT=8), that edge is E154.
- Back-to-back frames: the next start bit may begin immediately after the stop bit with zero idle time. This is fully supported, since the FSM returns to IDLE at mid-stop.
- Exclusivity: rx_valid and frame_err are never high in the same cycle. Neither ever lasts more than one cycle.
- No downstream backpressure: rx_valid fires regardless of the SIPO's full flag. Dropping bytes once the SIPO is full is the SIPO's behaviour, not this block's.
- Reset mid-frame: all state clears immediately and the partial byte is discarded. A new frame starting after reset deassertion is received normally.
- rx_data holds its value between frames and after frame errors.

Test Plan (CLKS_PER_BIT=16):
- Single byte: send 0xA5 framed 8N1 -> rx_data=0xA5; rx_valid high exactly one cycle, after edge E154; frame_err=0 throughout; busy=1 from E2 until return to IDLE.
- Glitch: rx low for 3 cycles, then high -> FSM back to IDLE by E10; no rx_valid, no frame_err; rx_data unchanged.
- Framing error: receive 0x11, then send 0x3C with the stop bit driven 0 and the line held low for 40 more cycles -> one frame_err pulse; no rx_valid; rx_data stays 0x11; busy stays high until rx returns high, then the next 0x55 frame is received correctly.
- Back-to-back: 16 frames carrying 0x00..0x0F with zero idle gap, output fed to a SIPO instance -> 16 rx_valid pulses in order, each with the matching byte; SIPO full=1 and parallel_out=128'h000102030405060708090A0B0C0D0E0F.
- Reset mid-frame: assert reset for 2 cycles during data bit 4 of 0xFF -> all outputs return to reset values at once; no rx_valid; a subsequent 0x81 frame produces rx_data=0x81 with one rx_valid pulse.

Source files
------------

// File: rtl/uart_rx_byte.sv
// UART 8N1 receiver: two-flop synchronizer, mid-bit sampling FSM, one-cycle
// rx_valid / frame_err strobes. A held-low line after a bad stop bit is absorbed.
module uart_rx_byte #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned HALF_BIT  = CLKS_PER_BIT / 2;
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK_WAIT
    } state_e;

    logic        sync1_q, sync2_q;
    logic        rx_s;
    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;
    logic        busy_q;

    assign rx_s = sync2_q;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d = DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK_WAIT;
                    end
                end
            end
            BREAK_WAIT: begin
                // Hold off decoding until the line has genuinely returned to idle.
                cnt_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at CLKS_PER_BIT=16: timing, glitch, framing
// error, back-to-back into a 128-bit SIPO model, and reset mid-frame.
module tb_uart_rx_byte;

    localparam int C = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Event monitor state, written only by the negedge monitor.
    int         valid_cnt = 0;
    int         ferr_cnt  = 0;
    int         both_cnt  = 0;
    int         long_cnt  = 0;
    logic       prev_valid = 1'b0;
    logic       prev_ferr  = 1'b0;
    logic [7:0] byte_q[$];
    logic       sipo_en = 1'b0;
    logic [127:0] sipo_q = '0;
    int         sipo_cnt = 0;

    uart_rx_byte #(.CLKS_PER_BIT(C)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            if (rx_valid) begin
                valid_cnt++;
                byte_q.push_back(rx_data);
                if (sipo_en && sipo_cnt < 16) begin
                    sipo_q = {sipo_q[119:0], rx_data};
                    sipo_cnt++;
                end
            end
            if (frame_err) ferr_cnt++;
            if (rx_valid && frame_err) both_cnt++;
            if ((rx_valid && prev_valid) || (frame_err && prev_ferr)) long_cnt++;
        end
        prev_valid = rx_valid;
        prev_ferr  = frame_err;
    end

    // Drives one 8N1 frame; entered and left 1 time unit after a rising edge.
    task automatic send_frame(input logic [7:0] d, input logic stop_v);
        rx = 1'b0;
        repeat (C) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (C) @(posedge clk);
            #1;
        end
        rx = stop_v;
        repeat (C) @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if ({rx_data, rx_valid, frame_err, busy} !== 11'h000) begin
            $display("FAIL reset_outputs: got data=%h v=%b fe=%b busy=%b, want 00/0/0/0",
                     rx_data, rx_valid, frame_err, busy);
        end else pass_cnt++;
        reset = 1'b0;
        idle_cycles(4);
    endtask

    task automatic test_single_byte;
        int v0, f0;
        v0 = valid_cnt;
        f0 = ferr_cnt;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                repeat (2) @(posedge clk);   // past E1
                #1;
                total_cnt++;
                if (busy !== 1'b0) $display("FAIL busy_before_E2: got %b want 0", busy);
                else pass_cnt++;
                @(posedge clk);              // past E2
                #1;
                total_cnt++;
                if (busy !== 1'b1) $display("FAIL busy_at_E2: got %b want 1", busy);
                else pass_cnt++;
                repeat (151) @(posedge clk); // past E153
                #1;
                total_cnt++;
                if (rx_valid !== 1'b0) $display("FAIL valid_early_E153: got %b want 0", rx_valid);
                else pass_cnt++;
                @(posedge clk);              // past E154
                #1;
                total_cnt++;
                if (rx_valid !== 1'b1 || rx_data !== 8'hA5)
                    $display("FAIL valid_at_E154: got v=%b data=%h want 1/a5", rx_valid, rx_data);
                else pass_cnt++;
                @(posedge clk);
                #1;
                total_cnt++;
                if (rx_valid !== 1'b0) $display("FAIL valid_width: got %b want 0", rx_valid);
                else pass_cnt++;
            end
        join
        idle_cycles(4);
        total_cnt++;
        if (valid_cnt - v0 !== 1 || ferr_cnt - f0 !== 0 || busy !== 1'b0)
            $display("FAIL single_counts: got valid=%0d ferr=%0d busy=%b want 1/0/0",
                     valid_cnt - v0, ferr_cnt - f0, busy);
        else pass_cnt++;
    endtask

    task automatic test_glitch;
        int v0, f0;
        v0 = valid_cnt;
        f0 = ferr_cnt;
        rx = 1'b0;
        repeat (3) @(posedge clk);   // E0..E2 sample low
        #1;
        rx = 1'b1;
        repeat (7) @(posedge clk);   // past E9
        #1;
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL glitch_busy_E9: got %b want 1", busy);
        else pass_cnt++;
        @(posedge clk);              // past E10
        #1;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL glitch_idle_E10: got %b want 0", busy);
        else pass_cnt++;
        idle_cycles(20);
        total_cnt++;
        if (valid_cnt != v0 || ferr_cnt != f0 || rx_data !== 8'hA5)
            $display("FAIL glitch_no_output: got valid+%0d ferr+%0d data=%h want 0/0/a5",
                     valid_cnt - v0, ferr_cnt - f0, rx_data);
        else pass_cnt++;
    endtask

    task automatic test_framing_error;
        int v0, f0;
        send_frame(8'h11, 1'b1);
        idle_cycles(4);
        total_cnt++;
        if (rx_data !== 8'h11) $display("FAIL ferr_pre_byte: got %h want 11", rx_data);
        else pass_cnt++;
        v0 = valid_cnt;
        f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        total_cnt++;
        if (ferr_cnt - f0 !== 1 || valid_cnt != v0 || rx_data !== 8'h11)
            $display("FAIL ferr_pulse: got ferr=%0d valid+%0d data=%h want 1/0/11",
                     ferr_cnt - f0, valid_cnt - v0, rx_data);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL ferr_break_busy: got %b want 1", busy);
        else pass_cnt++;
        idle_cycles(5);
        total_cnt++;
        if (busy !== 1'b0 || ferr_cnt - f0 !== 1)
            $display("FAIL ferr_release: got busy=%b ferr=%0d want 0/1", busy, ferr_cnt - f0);
        else pass_cnt++;
        send_frame(8'h55, 1'b1);
        idle_cycles(4);
        total_cnt++;
        if (rx_data !== 8'h55 || valid_cnt - v0 !== 1)
            $display("FAIL ferr_recover: got data=%h valid=%0d want 55/1", rx_data, valid_cnt - v0);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int v0, b0;
        v0 = valid_cnt;
        b0 = byte_q.size();
        sipo_en = 1'b1;
        for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b1);
        idle_cycles(4);
        sipo_en = 1'b0;
        total_cnt++;
        if (valid_cnt - v0 !== 16) $display("FAIL b2b_count: got %0d want 16", valid_cnt - v0);
        else pass_cnt++;
        for (int i = 0; i < 16; i++) begin
            total_cnt++;
            if (b0 + i >= byte_q.size())
                $display("FAIL b2b_byte%0d: got none want %h", i, 8'(i));
            else if (byte_q[b0 + i] !== 8'(i))
                $display("FAIL b2b_byte%0d: got %h want %h", i, byte_q[b0 + i], 8'(i));
            else pass_cnt++;
        end
        total_cnt++;
        if (sipo_cnt != 16 || sipo_q !== 128'h000102030405060708090A0B0C0D0E0F)
            $display("FAIL b2b_sipo: got full=%0d out=%h want 1/000102030405060708090a0b0c0d0e0f",
                     sipo_cnt == 16, sipo_q);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_frame;
        int v0;
        v0 = valid_cnt;
        rx = 1'b0;
        repeat (C) @(posedge clk);
        #1;
        rx = 1'b1;                    // 0xFF data bits
        repeat (4 * C + C / 2) @(posedge clk);
        #1;
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL mid_busy_before: got %b want 1", busy);
        else pass_cnt++;
        reset = 1'b1;
        #1;
        total_cnt++;
        if ({rx_data, rx_valid, frame_err, busy} !== 11'h000)
            $display("FAIL mid_async_clear: got data=%h v=%b fe=%b busy=%b want 00/0/0/0",
                     rx_data, rx_valid, frame_err, busy);
        else pass_cnt++;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (5 * C) @(posedge clk);
        #1;
        total_cnt++;
        if (valid_cnt != v0 || busy !== 1'b0)
            $display("FAIL mid_discard: got valid+%0d busy=%b want 0/0", valid_cnt - v0, busy);
        else pass_cnt++;
        send_frame(8'h81, 1'b1);
        idle_cycles(4);
        total_cnt++;
        if (rx_data !== 8'h81 || valid_cnt - v0 !== 1)
            $display("FAIL mid_next_frame: got data=%h valid=%0d want 81/1", rx_data, valid_cnt - v0);
        else pass_cnt++;
    endtask

    task automatic test_exclusivity;
        total_cnt++;
        if (both_cnt != 0 || long_cnt != 0)
            $display("FAIL strobe_exclusive: got overlap=%0d long=%0d want 0/0", both_cnt, long_cnt);
        else pass_cnt++;
    endtask

    initial begin
        test_reset;
        test_single_byte;
        test_glitch;
        test_framing_error;
        test_back_to_back;
        test_reset_mid_frame;
        test_exclusivity;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
